// File: rtl/piso_shift_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// piso_shift_tx : parallel-in serial-out transmitter with ready/busy/done handshake
// Revision 1.0
// ---------------------------------------------------------------------------
module piso_shift_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             q_out,
  output logic             q_bar
);

  localparam int                 c_cnt_w   = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_q;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;

  logic               w_first_bit;
  logic               w_next_bit;
  logic [WIDTH-1:0]   w_shift_nxt;

  // The register rotates rather than shifts so the outgoing bit position
  // always holds the bit currently on q_out.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit = d_in[WIDTH-1];
      assign w_next_bit  = r_shift[WIDTH-2];
      assign w_shift_nxt = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
    end else begin : g_lsb_first
      assign w_first_bit = d_in[0];
      assign w_next_bit  = r_shift[1];
      assign w_shift_nxt = {r_shift[0], r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_q     <= IDLE_LEVEL;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_state <= S_SHIFT;
            r_shift <= d_in;
            r_cnt   <= '0;
            r_q     <= w_first_bit;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_cnt == c_cnt_last) begin
            r_state <= S_DONE;
            r_q     <= IDLE_LEVEL;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_shift <= w_shift_nxt;
            r_cnt   <= r_cnt + c_cnt_one;
            r_q     <= w_next_bit;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_q     <= IDLE_LEVEL;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign q_out = r_q;
  assign q_bar = ~r_q;

endmodule
`default_nettype wire

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in serial-out transmitter: captures a WIDTH-bit word on a load request and drives it out one bit per clock on q_out.
- It is the sending end of the single-bit serial link fed into our D-latch/flip-flop capture stages.
- It provides a ready/busy/done handshake so an upstream controller can pace words.
- q_bar is driven as the complement of q_out, matching our storage-element outputs.

Parameters:
- WIDTH, 8: number of data bits per word (legal 2..32).
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_LEVEL, 1: value driven on q_out when no word is being sent.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  reset, asynchronous and active-high; forces all state to reset values immediately.
- d_in  input  WIDTH  parallel data word; sampled only on an accepted load.
- load  input  1  load request; accepted only when ready=1 at the rising edge.
- ready  output  1  block is idle and will accept load.
- busy  output  1  a word is being shifted out.
- done  output  1  one-cycle pulse after the last bit has been driven.
- q_out  output  1  registered serial data output.
- q_bar  output  1  combinational ~q_out.

Behaviour:
- State machine states:
  - IDLE: ready=1, busy=0, done=0, q_out=IDLE_LEVEL.
  - SHIFT: ready=0, busy=1, done=0.
  - DONE: ready=0, busy=0, done=1, q_out=IDLE_LEVEL.
- Reset (clr=1, asynchronous):
  - State goes to IDLE; shift register and bit counter go to 0.
  - Outputs: q_out=IDLE_LEVEL, ready=1, busy=0, done=0.
  - Holds while clr=1.
  - Reset mid-word aborts the word with no done pulse; the next load after clr deasserts starts a fresh word.
- IDLE -> SHIFT:
  - On an edge with load=1, d_in is copied into the shift register and the bit counter is cleared to 0.
  - q_out takes the first bit at the same edge: d_in[WIDTH-1] if MSB_FIRST, else d_in[0].
  - The first bit is therefore visible in the cycle after the accepting edge (latency 1).
- SHIFT:
  - Each edge advances the shift register by one position and increments the counter.
  - q_out takes the next bit, so each bit is held for exactly one clock.
  - On the edge where the counter equals WIDTH-1, state goes to DONE and q_out returns to IDLE_LEVEL.
  - The word occupies exactly WIDTH cycles on q_out.
- DONE -> IDLE: unconditional on the next edge; done is high for exactly one cycle.
- load while busy or in DONE: ignored. No queueing, no data corruption, d_in not resampled.
- Back-to-back words:
  - Minimum spacing from one accepting edge to the next is WIDTH+2 clocks.
  - load held high continuously yields one word every WIDTH+2 cycles.
- d_in changes after the accepting edge have no effect on the word being sent.
- X/Z on load while in IDLE: treated as not-accepted and the block remains in IDLE; the bench must not rely on this.
- Counter width: clog2(WIDTH) bits. The counter does not wrap during normal operation and is reset to 0 on every accept.
- q_bar equals ~q_out at all times, including during reset.

Test Plan:
- Reset value: assert clr mid-cycle with no clock edge -> q_out=1, q_bar=0, ready=1, busy=0, done=0 immediately.
- MSB-first word: WIDTH=8, MSB_FIRST=1, load=1 with d_in=8'hA5 for one cycle at edge 0 -> q_out = 1,0,1,0,0,1,0,1 during cycles 1..8, busy=1 during cycles 1..8, done=1 in cycle 9 only, ready=1 from cycle 10.
- LSB-first word: MSB_FIRST=0, load d_in=8'h01 -> q_out = 1,0,0,0,0,0,0,0 during cycles 1..8, then IDLE_LEVEL.
- Load ignored while busy: load 8'hF0, then pulse load with d_in=8'h0F at cycle 3 -> serial stream is still 1,1,1,1,0,0,0,0 and only one done pulse occurs.
- Abort: load 8'hFF, assert clr during cycle 4 -> outputs return to reset values asynchronously with no done pulse; after release, load 8'h3C transmits 0,0,1,1,1,1,0,0 correctly.
- Continuous load: load held at 1 with d_in=8'h81 -> accepts at edges 0, 10, 20, with each word framed identically and done in cycles 9, 19, 29.
